// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, drives the ALU Ctrl code and all datapath enables.
module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             ZeroFlag,
   output logic [2:0]       Ctrl,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSrc,
   output logic             PCEn,
   output logic [3:0]       State,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state, state_nx;
   logic       set_illegal, retire;
   logic       funct_ok;
   logic [2:0] funct_ctrl;
   logic       mem_write_d, ir_write_d, reg_write_d, pc_write_d, branch_d;

   // R-type function decode shared by DECODE legality check and EXEC ALU code
   always_comb begin
      funct_ok   = 1'b1;
      funct_ctrl = ALU_ADD;
      case (Funct)
         6'b100000: funct_ctrl = ALU_ADD;
         6'b100010: funct_ctrl = ALU_SUB;
         6'b100100: funct_ctrl = ALU_AND;
         6'b100101: funct_ctrl = ALU_OR;
         6'b101010: funct_ctrl = ALU_SLT;
         default:   funct_ok   = 1'b0;
      endcase
   end

   // State register, sticky illegal flag and retired-instruction counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         Illegal    <= 1'b0;
         InstrCount <= '0;
      end else begin
         state <= state_nx;
         if (set_illegal) Illegal    <= 1'b1;
         if (retire)      InstrCount <= InstrCount + CNT_W'(1);
      end
   end

   // Next-state logic
   always_comb begin
      state_nx    = S_FETCH;
      set_illegal = 1'b0;
      retire      = 1'b0;
      case (state)
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            if (Op == OP_LW || Op == OP_SW)       state_nx = S_MEMADR;
            else if (Op == OP_RTYPE && funct_ok)  state_nx = S_EXEC;
            else if (Op == OP_BEQ)                state_nx = S_BRANCH;
            else if (Op == OP_ADDI)               state_nx = S_ADDIEX;
            else if (Op == OP_J)                  state_nx = S_JUMP;
            else                                  set_illegal = 1'b1;
         end
         S_MEMADR: begin
            if (Op == OP_LW)      state_nx = S_MEMRD;
            else if (Op == OP_SW) state_nx = S_MEMWR;
         end
         S_MEMRD:  state_nx = S_MEMWB;
         S_EXEC:   state_nx = S_ALUWB;
         S_ADDIEX: state_nx = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
         default:  state_nx = S_FETCH;
      endcase
   end

   // Moore output decode of the current state
   always_comb begin
      Ctrl        = ALU_ADD;
      IorD        = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      mem_write_d = 1'b0;
      ir_write_d  = 1'b0;
      reg_write_d = 1'b0;
      pc_write_d  = 1'b0;
      branch_d    = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write_d = 1'b1;
            ALUSrcB    = 2'b01;
            pc_write_d = 1'b1;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg    = 1'b1;
            reg_write_d = 1'b1;
         end
         S_MEMWR: begin
            IorD        = 1'b1;
            mem_write_d = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            Ctrl    = funct_ctrl;
         end
         S_ALUWB: begin
            RegDst      = 1'b1;
            reg_write_d = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            Ctrl     = ALU_SUB;
            PCSrc    = 2'b01;
            branch_d = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: reg_write_d = 1'b1;
         S_JUMP: begin
            PCSrc      = 2'b10;
            pc_write_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Architectural write enables are suppressed while reset is asserted
   assign MemWrite = rst_n & mem_write_d;
   assign IRWrite  = rst_n & ir_write_d;
   assign RegWrite = rst_n & reg_write_d;
   assign PCEn     = rst_n & (pc_write_d | (branch_d & ZeroFlag));
   assign State    = state;

endmodule
